mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported `main_mem` between the CPU instruction-fetch port and the load/store port. It latches one request at a time and drives `main_mem`'s `ce`/`wr_fg`/`addr`/`sel`/`in_data` for exactly one cycle. It registers the read result and returns a one-cycle acknowledge to the winner. The data port has fixed priority, and a starvation limit guarantees forward progress for instruction fetch.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port main_mem arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  localparam logic [3:0] FETCH_SEL = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_RESP   = ST_RESP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose: shares single-ported main_mem between instruction fetch (i_*) and load/store (d_*);
// Latency: request seen in IDLE -> ACCESS next cycle -> ack the cycle after (one access per 3 cycles);
// Backpressure: requesters hold req until their one-cycle ack; data has priority, fetch forced after STARVE_LIMIT.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_req/i_addr     : fetch request;   i_ack/i_rdata : fetch completion and word
//   d_req/d_we/d_addr/d_sel/d_wdata : load/store request; d_ack/d_rdata : completion and load word
//   mem_ce/mem_wr_fg/mem_addr/mem_sel/mem_wdata/mem_rdata : main_mem port (driven only in ACCESS)
//   busy             : FSM not idle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_ce,
  output logic        mem_wr_fg,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  logic        src_q, src_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        grant_i;
  logic        in_access;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    addr_d       = addr_q;
    we_d         = we_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    starve_cnt_d = starve_cnt_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_i      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          // Data wins a tie unless fetch has already waited LIMIT data grants.
          grant_i = i_req && (!d_req || (starve_cnt_q == LIMIT));
          state_d = S_ACCESS;
          if (grant_i) begin
            src_d        = SRC_I;
            addr_d       = i_addr;
            we_d         = 1'b0;
            sel_d        = FETCH_SEL;
            wdata_d      = '0;
            starve_cnt_d = '0;
          end else begin
            src_d   = SRC_D;
            addr_d  = d_addr;
            we_d    = d_we;
            sel_d   = d_sel;
            wdata_d = d_wdata;
            if (!i_req) begin
              starve_cnt_d = '0;
            end else if (starve_cnt_q != LIMIT) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (!we_q) begin
          if (src_q == SRC_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            i_rdata_d = mem_rdata;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_q        <= SRC_I;
      addr_q       <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      wdata_q      <= '0;
      starve_cnt_q <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      wdata_q      <= wdata_d;
      starve_cnt_q <= starve_cnt_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // The memory port is a pure decode of ACCESS so nothing can write outside it.
  assign in_access = (state_q == S_ACCESS);
  assign mem_ce    = in_access;
  assign mem_wr_fg = in_access && we_q && (src_q == SRC_D);
  assign mem_addr  = in_access ? addr_q : '0;
  assign mem_sel   = in_access ? ((src_q == SRC_D) ? sel_q : FETCH_SEL) : '0;
  assign mem_wdata = in_access ? wdata_q : '0;

  assign i_ack   = (state_q == S_RESP) && (src_q == SRC_I);
  assign d_ack   = (state_q == S_RESP) && (src_q == SRC_D);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a main_mem model and ack scoreboards.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_sel;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_ce;
  logic        mem_wr_fg;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_ce(mem_ce), .mem_wr_fg(mem_wr_fg), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main_mem model: combinational read, byte-enabled write at the rising edge.
  logic [31:0] mem  [0:255];
  logic [31:0] refm [0:255];
  assign mem_rdata = mem_ce ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_ce && mem_wr_fg) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_sel[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Scoreboards: expected read data per port, pushed when a request is driven.
  logic [31:0] i_q[$];
  logic [31:0] d_q[$];
  logic [31:0] d_last;
  logic        bus_chk_en;
  logic        cur_d_act;
  logic        cur_d_we;
  logic [31:0] cur_d_addr;

  always @(negedge clk) begin
    if (i_ack) begin
      if (i_q.size() == 0) chk("i_ack_unexpected", 32'd1, 32'd0);
      else chk("i_rdata", i_rdata, i_q.pop_front());
    end
    if (d_ack) begin
      if (d_q.size() == 0) chk("d_ack_unexpected", 32'd1, 32'd0);
      else chk("d_rdata", d_rdata, d_q.pop_front());
    end
    if (bus_chk_en) begin
      if (mem_ce)
        chk("wr_fg", {31'd0, mem_wr_fg},
            {31'd0, cur_d_act && cur_d_we && (mem_addr == cur_d_addr)});
      else
        chk("idle_bus", mem_addr | mem_wdata | {27'd0, mem_wr_fg, mem_sel}, 32'd0);
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    d_last = 32'h0;
  endtask

  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd);
    bit got;
    if (we) begin
      refm[addr[9:2]] = merge(refm[addr[9:2]], wd, sel);
    end else begin
      d_last = refm[addr[9:2]];
    end
    d_q.push_back(d_last);
    cur_d_we = we; cur_d_addr = addr; cur_d_act = 1'b1;
    d_we = we; d_addr = addr; d_sel = sel; d_wdata = wd; d_req = 1'b1;
    got = 0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (d_ack) got = 1;
    end
    d_req = 1'b0;
    cur_d_act = 1'b0;
    if (!got) chk("d_timeout", 32'd0, 32'd1);
  endtask

  task automatic i_txn(input logic [31:0] addr);
    bit got;
    i_q.push_back(refm[addr[9:2]]);
    i_addr = addr; i_req = 1'b1;
    got = 0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (i_ack) got = 1;
    end
    i_req = 1'b0;
    if (!got) chk("i_timeout", 32'd0, 32'd1);
  endtask

  logic [5:0] seq;
  int         nack;
  int         t_d, t_i, cyc;

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_sel = 0; d_wdata = 0;
    bus_chk_en = 0; cur_d_act = 0; cur_d_we = 0; cur_d_addr = 0; d_last = 0;
    for (int w = 0; w < 256; w++) begin
      mem[w] = $urandom; refm[w] = mem[w];
    end
    mem[8'h10] = 32'hDEADBEEF; refm[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'h11223344; refm[8'h20] = 32'h11223344;
    do_reset();

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);

    // Single fetch, cycle-exact
    i_q.push_back(32'hDEADBEEF);
    i_addr = 32'h40; i_req = 1'b1;
    @(negedge clk);
    chk("f_ce", {31'd0, mem_ce}, 32'd1);
    chk("f_wr", {31'd0, mem_wr_fg}, 32'd0);
    chk("f_addr", mem_addr, 32'h40);
    chk("f_sel", {28'd0, mem_sel}, 32'hF);
    @(negedge clk);
    chk("f_ack", {31'd0, i_ack}, 32'd1);
    chk("f_rdata", i_rdata, 32'hDEADBEEF);
    i_req = 1'b0;
    @(negedge clk);
    chk("f_busy_low", {31'd0, busy}, 32'd0);
    chk("f_i_ack_low", {31'd0, i_ack}, 32'd0);

    // Byte store then load
    d_txn(1'b1, 32'h80, 4'b0100, 32'h00AB0000);
    chk("st_keeps_rdata", d_rdata, 32'd0);
    chk("st_mem", mem[8'h20], 32'h11AB3344);
    d_txn(1'b0, 32'h80, 4'b1111, 32'h0);
    chk("ld_rdata", d_rdata, 32'h11AB3344);

    // Collision from reset release
    rst = 1'b1; repeat (2) @(negedge clk);
    i_addr = 32'h44; d_we = 0; d_addr = 32'h84; d_sel = 4'hF;
    i_req = 1'b1; d_req = 1'b1; rst = 1'b0; d_last = 32'h0;
    i_q.push_back(refm[8'h11]);
    d_last = refm[8'h21]; d_q.push_back(d_last);
    t_d = -1; t_i = -1;
    for (int k = 0; k < 30 && (t_i < 0 || t_d < 0); k++) begin
      @(negedge clk);
      if (d_ack) begin t_d = k; d_req = 1'b0; end
      if (i_ack) begin t_i = k; i_req = 1'b0; end
    end
    i_req = 0; d_req = 0;
    chk("coll_d_first", {31'd0, (t_d >= 0) && (t_i > t_d)}, 32'd1);
    chk("coll_gap", t_i - t_d, 32'd3);

    // Starvation: data held continuously, fetch pending
    do_reset();
    d_we = 0; d_addr = 32'h88; d_sel = 4'hF; i_addr = 32'h48;
    d_last = refm[8'h22];
    for (int k = 0; k < 5; k++) d_q.push_back(d_last);
    i_q.push_back(refm[8'h12]);
    i_req = 1'b1; d_req = 1'b1;
    seq = 0; nack = 0;
    for (int k = 0; k < 60 && nack < 6; k++) begin
      @(negedge clk);
      if (d_ack) begin seq = {seq[4:0], 1'b1}; nack++; end
      if (i_ack) begin seq = {seq[4:0], 1'b0}; nack++; i_req = 1'b0; end
      if (nack == 6) d_req = 1'b0;
    end
    i_req = 0; d_req = 0;
    chk("starve_cnt", nack, 32'd6);
    chk("starve_seq", {26'd0, seq}, 32'b111101);

    // Reset during a store's ACCESS cycle
    do_reset();
    d_we = 1; d_addr = 32'h8C; d_sel = 4'b0011; d_wdata = 32'h0000CAFE; d_req = 1'b1;
    refm[8'h23] = merge(refm[8'h23], 32'h0000CAFE, 4'b0011);
    @(negedge clk);
    chk("rs_wr", {31'd0, mem_wr_fg}, 32'd1);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("rs_outs", {26'd0, busy, i_ack, d_ack, mem_ce, mem_wr_fg, |mem_sel}, 32'd0);
    chk("rs_bus", mem_addr | mem_wdata | i_rdata | d_rdata, 32'd0);
    chk("rs_mem", mem[8'h23], refm[8'h23]);
    rst = 1'b0; d_last = 32'h0;
    t_d = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (d_ack) t_d++;
    end
    chk("rs_no_ack", t_d, 32'd0);

    // Random concurrent traffic: fetch in words 0..63, data in words 128..191
    bus_chk_en = 1'b1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          i_txn({22'd0, 8'($urandom_range(0, 63)), 2'b00});
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          logic [3:0] s;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          s = 4'($urandom_range(1, 15));
          d_txn(1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(128, 191)), 2'b00},
                s, $urandom);
        end
      end
    join
    bus_chk_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int w = 128; w < 192; w++) chk("mem_final", mem[w], refm[w]);
    chk("i_q_empty", i_q.size(), 32'd0);
    chk("d_q_empty", d_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
